// File: rtl/zbt_wb_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : zbt_wb_writer                                              |
// | Description : Write-back buffer feeding ZBT bank 1. Queues processed     |
// |               pixel pairs in a small FIFO, coalesces repeated writes to  |
// |               the newest address, drains one word per arbiter grant and  |
// |               applies the ZBT two-cycle write-data delay.                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module zbt_wb_writer #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 36,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [ADDR_W-1:0]          in_addr,
  input  logic                       wr_slot,
  input  logic                       clr_ovf,
  output logic [ADDR_W-1:0]          zbt_addr,
  output logic                       zbt_we,
  output logic [DATA_W-1:0]          zbt_wdata,
  output logic                       zbt_oe,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow
);

  localparam int C_PTR_W = $clog2(DEPTH);
  localparam int C_CNT_W = C_PTR_W + 1;
  localparam logic [C_CNT_W-1:0] C_FULL_COUNT = C_CNT_W'(DEPTH);

  // FIFO storage (no reset needed: validity is tracked by the pointers/count)
  logic [ADDR_W-1:0]  r_addr_mem [DEPTH];
  logic [DATA_W-1:0]  r_data_mem [DEPTH];

  logic [C_PTR_W-1:0] r_head;
  logic [C_PTR_W-1:0] r_tail;
  logic [C_CNT_W-1:0] r_count;

  // Issue-stage data and the first data-delay stage
  logic [DATA_W-1:0]  r_iss_data;
  logic [DATA_W-1:0]  r_d1_data;
  logic               r_d1_valid;

  logic               w_empty;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_coalesce;
  logic               w_drop;
  logic [C_PTR_W-1:0] w_last_idx;

  // The most recently pushed entry sits just behind the tail; it is the one
  // being popped only when it is also the sole entry.
  always_comb begin
    w_empty    = (r_count == '0);
    w_full     = (r_count == C_FULL_COUNT);
    w_last_idx = r_tail - 1'b1;
    w_pop      = wr_slot && !w_empty;
    w_coalesce = in_valid && !w_empty &&
                 (in_addr == r_addr_mem[w_last_idx]) &&
                 !(w_pop && (r_count == C_CNT_W'(1)));
    w_push     = in_valid && !w_coalesce && (!w_full || w_pop);
    w_drop     = in_valid && !w_coalesce && w_full && !w_pop;
  end

  // FIFO storage write: new entry at the tail, or in-place data merge
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr_mem[r_tail] <= in_addr;
      r_data_mem[r_tail] <= in_data;
    end else if (w_coalesce) begin
      r_data_mem[w_last_idx] <= in_data;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow flag; a drop in the same cycle beats the clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (w_drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  // Issue stage: address/enable plus the data that will follow two cycles later
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zbt_addr   <= '0;
      zbt_we     <= 1'b0;
      r_iss_data <= '0;
    end else begin
      zbt_we <= w_pop;
      if (w_pop) begin
        zbt_addr   <= r_addr_mem[r_head];
        r_iss_data <= r_data_mem[r_head];
      end
    end
  end

  // Data delay stages: d1 then the bus-facing d2 registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_d1_data  <= '0;
      r_d1_valid <= 1'b0;
      zbt_wdata  <= '0;
      zbt_oe     <= 1'b0;
    end else begin
      r_d1_valid <= zbt_we;
      if (zbt_we) r_d1_data <= r_iss_data;
      zbt_oe <= r_d1_valid;
      if (r_d1_valid) zbt_wdata <= r_d1_data;
    end
  end

  assign fifo_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_zbt_wb_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_zbt_wb_writer                                           |
// | Description : Directed self-checking bench for zbt_wb_writer.            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_zbt_wb_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [35:0] in_data;
  logic [18:0] in_addr;
  logic        wr_slot;
  logic        clr_ovf;
  logic [18:0] zbt_addr;
  logic        zbt_we;
  logic [35:0] zbt_wdata;
  logic        zbt_oe;
  logic [3:0]  fifo_count;
  logic        overflow;

  int n_vec = 0;
  int n_err = 0;

  logic [18:0] we_q [$];
  logic [35:0] oe_q [$];

  zbt_wb_writer #(.ADDR_W(19), .DATA_W(36), .DEPTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_addr    (in_addr),
    .wr_slot    (wr_slot),
    .clr_ovf    (clr_ovf),
    .zbt_addr   (zbt_addr),
    .zbt_we     (zbt_we),
    .zbt_wdata  (zbt_wdata),
    .zbt_oe     (zbt_oe),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Bus monitor: log every issued address and every driven data word
  always @(negedge clk) begin
    if (zbt_we) we_q.push_back(zbt_addr);
    if (zbt_oe) oe_q.push_back(zbt_wdata);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [18:0] a, input logic [35:0] d);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_addr = '0;
    wr_slot = 1'b0; clr_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_addr",  64'(zbt_addr),   64'h0);
    check("rst_we",    64'(zbt_we),     64'h0);
    check("rst_wdata", 64'(zbt_wdata),  64'h0);
    check("rst_oe",    64'(zbt_oe),     64'h0);
    check("rst_count", 64'(fifo_count), 64'h0);
    check("rst_ovf",   64'(overflow),   64'h0);
    reset = 1'b0;
    tick();

    // Single write: input-to-bus latency
    wr_slot = 1'b1;
    push(19'h12345, 36'hA_BCDE_F012);
    check("single_count_push", 64'(fifo_count), 64'h1);
    check("single_we_pre",     64'(zbt_we),     64'h0);
    tick();
    check("single_we",    64'(zbt_we),     64'h1);
    check("single_addr",  64'(zbt_addr),   64'h12345);
    check("single_count", 64'(fifo_count), 64'h0);
    tick();
    check("single_we_off", 64'(zbt_we), 64'h0);
    check("single_oe_pre", 64'(zbt_oe), 64'h0);
    tick();
    check("single_oe",    64'(zbt_oe),    64'h1);
    check("single_wdata", 64'(zbt_wdata), 64'hA_BCDE_F012);
    tick();
    check("single_oe_off", 64'(zbt_oe), 64'h0);
    check("single_wdata_hold", 64'(zbt_wdata), 64'hA_BCDE_F012);

    // Coalesce two writes to the same address
    wr_slot = 1'b0;
    push(19'h100, 36'h1);
    push(19'h100, 36'h2);
    check("coal_count", 64'(fifo_count), 64'h1);
    we_q.delete(); oe_q.delete();
    wr_slot = 1'b1;
    repeat (6) tick();
    wr_slot = 1'b0;
    check("coal_nwrites", 64'(we_q.size()), 64'h1);
    check("coal_ndata",   64'(oe_q.size()), 64'h1);
    if (we_q.size() == 1) check("coal_addr", 64'(we_q[0]), 64'h100);
    if (oe_q.size() == 1) check("coal_data", 64'(oe_q[0]), 64'h2);

    // Fill past capacity and drain in order
    for (int i = 0; i < 9; i++) push(19'(32'h200 + i), 36'(64'h1000 + i));
    check("fill_count", 64'(fifo_count), 64'h8);
    check("fill_ovf",   64'(overflow),   64'h1);
    we_q.delete(); oe_q.delete();
    wr_slot = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("drain_we_%0d", i), 64'(zbt_we), 64'h1);
    end
    wr_slot = 1'b0;
    check("drain_count", 64'(fifo_count), 64'h0);
    repeat (4) tick();
    check("drain_nwrites", 64'(we_q.size()), 64'h8);
    check("drain_ndata",   64'(oe_q.size()), 64'h8);
    for (int i = 0; i < 8 && i < we_q.size() && i < oe_q.size(); i++) begin
      check($sformatf("drain_addr_%0d", i), 64'(we_q[i]), 64'h200 + 64'(i));
      check($sformatf("drain_data_%0d", i), 64'(oe_q[i]), 64'h1000 + 64'(i));
    end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("clr_ovf", 64'(overflow), 64'h0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 8; i++) push(19'(32'h300 + i), 36'(64'h3000 + i));
    check("full_count", 64'(fifo_count), 64'h8);
    we_q.delete(); oe_q.delete();
    wr_slot = 1'b1;
    push(19'h3FF, 36'h3FFF);
    check("full_pp_count", 64'(fifo_count), 64'h8);
    check("full_pp_ovf",   64'(overflow),   64'h0);
    repeat (10) tick();
    wr_slot = 1'b0;
    repeat (4) tick();
    check("full_pp_nwrites", 64'(we_q.size()), 64'h9);
    if (we_q.size() == 9) begin
      check("full_pp_first", 64'(we_q[0]), 64'h300);
      check("full_pp_last",  64'(we_q[8]), 64'h3FF);
    end
    if (oe_q.size() == 9) check("full_pp_last_data", 64'(oe_q[8]), 64'h3FFF);

    // Pointer wrap: 20 pushes with sparse grants
    we_q.delete(); oe_q.delete();
    for (int i = 0; i < 20; i++) begin
      wr_slot = (i % 3 != 0);
      push(19'(32'h400 + i), 36'(64'h5_0000_0000 + 64'(i) * 64'h111));
    end
    wr_slot = 1'b1;
    repeat (12) tick();
    wr_slot = 1'b0;
    repeat (4) tick();
    check("wrap_nwrites", 64'(we_q.size()), 64'd20);
    check("wrap_ndata",   64'(oe_q.size()), 64'd20);
    check("wrap_ovf",     64'(overflow),    64'h0);
    for (int i = 0; i < 20 && i < we_q.size() && i < oe_q.size(); i++) begin
      check($sformatf("wrap_addr_%0d", i), 64'(we_q[i]), 64'h400 + 64'(i));
      check($sformatf("wrap_data_%0d", i), 64'(oe_q[i]), 64'h5_0000_0000 + 64'(i) * 64'h111);
    end

    // Asynchronous reset in the middle of a write
    wr_slot = 1'b1;
    push(19'h500, 36'h5555);
    tick();
    check("mid_we_before", 64'(zbt_we), 64'h1);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_we",    64'(zbt_we),     64'h0);
    check("mid_rst_addr",  64'(zbt_addr),   64'h0);
    check("mid_rst_count", 64'(fifo_count), 64'h0);
    check("mid_rst_oe",    64'(zbt_oe),     64'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("idle_we_%0d", i), 64'(zbt_we), 64'h0);
      check($sformatf("idle_oe_%0d", i), 64'(zbt_oe), 64'h0);
    end
    wr_slot = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
